pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_W, 64: width of each datapath word (ALU result, adder output, store data).
- NWORD, 3: number of DATA_W words carried per entry.
- RD_W, 5: destination register index width.
- CTRL_W, 6: control bit count (branch, memread, memtoreg, memwrite, regwrite, addermuxselect).
- CNT_W, 16: width of the flush-drop counter.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- flush, in, 1: kills every held entry and the entry offered this cycle.
- in_valid, in, 1: upstream entry offered.
- in_ready, out, 1: block accepts an entry this cycle.
- in_data, in, NWORD*DATA_W: datapath words.
- in_zero, in, 1: ALU zero flag.
- in_rd, in, RD_W: destination register.
- in_ctrl, in, CTRL_W: control bits.
- out_valid, out, 1: entry presented downstream.
- out_ready, in, 1: downstream consumes the entry.
- out_data, out, NWORD*DATA_W: datapath words of the presented entry.
- out_zero, out, 1: ALU zero flag of the presented entry.
- out_rd, out, RD_W: destination register of the presented entry.
- out_ctrl, out, CTRL_W: control bits of the presented entry.
- occupancy, out, 2: held entries (0..2).
- flush_drops, out, CNT_W: saturating count of entries discarded by flush.

Function
REQ-003 Storage SHALL be two entry slots, MAIN (drives outputs) and SKID; each slot holds data, zero, rd, ctrl and a valid bit.
REQ-004 All state SHALL update only on rising clk; in_ready SHALL equal NOT SKID.valid, driven from a register with no combinational path from out_ready.
REQ-005 Input fire = in_valid AND in_ready; output fire = out_valid AND out_ready; out_valid SHALL equal MAIN.valid.
REQ-006 When out_valid=0, out_data, out_zero, out_rd and out_ctrl SHALL all be zero (bubble); no control bit SHALL be asserted on a bubble.
REQ-007 Entries SHALL leave in acceptance order; none SHALL be duplicated or lost except by flush or reset.
REQ-008 Latency SHALL be 1 cycle: an entry accepted into an empty block is presented on the following cycle; sustained throughput SHALL be 1 entry/cycle with out_ready held high.
REQ-009 Update rules without flush:
- MAIN empty, input fire -> MAIN <= input.
- MAIN full, output fire, SKID full -> MAIN <= SKID; SKID <= input if input fire, else empty.
- MAIN full, output fire, SKID empty -> MAIN <= input if input fire, else empty.
- MAIN full, no output fire, input fire -> SKID <= input.
- Otherwise -> hold.
REQ-010 occupancy SHALL equal MAIN.valid + SKID.valid, registered; the value 2 implies in_ready=0 on the same cycle.
REQ-011 flush=1 SHALL, at the next edge, invalidate MAIN and SKID, discard any input fire of that cycle, and leave in_ready=1, regardless of out_ready.
REQ-012 On flush, flush_drops SHALL add MAIN.valid + SKID.valid + (input fire), saturating at 2^CNT_W-1 without wrapping.
REQ-013 An output fire in the flush cycle SHALL still be a legal consumption; that entry SHALL NOT be counted as dropped.
REQ-014 Payload fields of an invalid slot are don't-care internally, but REQ-006 masking SHALL always apply at the outputs.

Reset
REQ-015 reset=1 at a rising edge SHALL clear both slots, set occupancy=0, flush_drops=0, out_valid=0, in_ready=1 and all out_* to 0; reset SHALL take priority over flush and any fire.
REQ-016 Reset mid-operation SHALL discard all held entries without counting them in flush_drops.

Verification
REQ-017 Reset, then in_valid=1 with in_data word0=0x1234, rd=7, ctrl=6'b010011, out_ready=1 -> next cycle out_valid=1, out_rd=7, out_ctrl=6'b010011; following cycle bubble with all outputs 0.
REQ-018 Stream 10 entries back-to-back with out_ready=1 -> 10 consecutive output cycles in order; in_ready stays 1; occupancy stays 1.
REQ-019 out_ready=0, offer entries A, B, C -> A in MAIN, B in SKID, occupancy=2, in_ready=0, C held upstream; raise out_ready -> A, B, C emerge on consecutive cycles.
REQ-020 occupancy=2 with in_valid=1, flush=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, flush_drops=2 (the offered entry is not accepted because in_ready=0).
REQ-021 Force flush_drops to 2^CNT_W-2, then flush with 2 held entries -> flush_drops=2^CNT_W-1, with no wrap.
REQ-022 reset and flush asserted together, with held entries -> all cleared, flush_drops=0.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for the skid-buffered pipeline stage:
// the upstream entry port and the downstream presented entry.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64,
  parameter int NWORD  = 3,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 6
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NWORD*DATA_W-1:0] in_data;
  logic                    in_zero;
  logic [RD_W-1:0]         in_rd;
  logic [CTRL_W-1:0]       in_ctrl;

  logic                    out_valid;
  logic                    out_ready;
  logic [NWORD*DATA_W-1:0] out_data;
  logic                    out_zero;
  logic [RD_W-1:0]         out_rd;
  logic [CTRL_W-1:0]       out_ctrl;

  // The stage itself: consumes upstream entries, presents downstream ones.
  modport slave (
    input  in_valid, in_data, in_zero, in_rd, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_rd, out_ctrl
  );

  // The surrounding pipeline: offers entries and consumes presented ones.
  modport master (
    output in_valid, in_data, in_zero, in_rd, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_rd, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-slot (MAIN + SKID) pipeline register with registered in_ready,
// bubble masking on the outputs, flush, and a saturating flush-drop counter.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int NWORD  = 3,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_drops
);
  localparam int PAY_W = NWORD * DATA_W;
  localparam int ENT_W = PAY_W + 1 + RD_W + CTRL_W;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] main_ent;
  logic [ENT_W-1:0] skid_ent;
  logic [ENT_W-1:0] out_ent;
  logic             main_vld;
  logic             skid_vld;
  logic             main_vld_n;
  logic             skid_vld_n;
  logic             ld_main_in;
  logic             ld_main_skid;
  logic             ld_skid;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       drop_inc;
  logic [1:0]       occ_q;
  logic [CNT_W-1:0] drops_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  function automatic logic [ENT_W-1:0] bubble_mask(input logic             vld,
                                                   input logic [ENT_W-1:0] ent);
    return vld ? ent : '0;
  endfunction

  assign in_ent   = {bus.in_data, bus.in_zero, bus.in_rd, bus.in_ctrl};
  assign in_fire  = bus.in_valid & ~skid_vld;
  assign out_fire = main_vld & bus.out_ready;

  // An entry consumed downstream during a flush is not a drop.
  assign drop_inc = {1'b0, main_vld & ~bus.out_ready}
                  + {1'b0, skid_vld}
                  + {1'b0, in_fire};

  always_comb begin
    main_vld_n   = main_vld;
    skid_vld_n   = skid_vld;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!main_vld) begin
      if (in_fire) begin
        main_vld_n = 1'b1;
        ld_main_in = 1'b1;
      end
    end else if (out_fire) begin
      if (skid_vld) begin
        ld_main_skid = 1'b1;
        skid_vld_n   = in_fire;
        ld_skid      = in_fire;
      end else begin
        main_vld_n = in_fire;
        ld_main_in = in_fire;
      end
    end else if (in_fire) begin
      skid_vld_n = 1'b1;
      ld_skid    = 1'b1;
    end
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end
  end

  // Control state: valid bits, occupancy and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      occ_q    <= 2'd0;
      drops_q  <= '0;
    end else begin
      main_vld <= main_vld_n;
      skid_vld <= skid_vld_n;
      occ_q    <= {1'b0, main_vld_n} + {1'b0, skid_vld_n};
      if (flush)
        drops_q <= sat_add(drops_q, drop_inc);
    end
  end

  // Payload slots carry no reset; outputs are masked by MAIN's valid bit.
  always_ff @(posedge clk) begin
    if (ld_main_in)
      main_ent <= in_ent;
    else if (ld_main_skid)
      main_ent <= skid_ent;
    if (ld_skid)
      skid_ent <= in_ent;
  end

  assign out_ent       = bubble_mask(main_vld, main_ent);
  assign bus.out_valid = main_vld;
  assign bus.in_ready  = ~skid_vld;
  assign {bus.out_data, bus.out_zero, bus.out_rd, bus.out_ctrl} = out_ent;
  assign occupancy     = occ_q;
  assign flush_drops   = drops_q;
endmodule
